// File: rtl/robo_ctrl_pkg.sv
// Shared types and defaults for the robot operator-control front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package robo_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        STEP     = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    localparam int DEF_DEB_CYCLES = 16;
    localparam int DEF_RUN_DIV    = 4;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter, 1-cycle press pulse.
// Latency: raw rising edge to o_press is 2 + DEB_CYCLES clocks.
// Backpressure: none; the pulse fires once per accepted 0->1 level change, releases are silent.
module btn_debounce
    import robo_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_lvl;
    logic          r_press;
    logic [DW-1:0] r_cnt;

    // Bring the raw, asynchronous button into the clock domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lvl   <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 != r_lvl) begin
                if (r_cnt == DW'(DEB_CYCLES - 1)) begin
                    r_lvl   <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + DW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/robo_step_ctrl.sv
// Operator front end for the robot FSM: debounced buttons -> robot reset, RUN/STEP step enable, HALT latch.
// Latency: press pulse to robo_en/robo_reset/mode change is 1 clock; all outputs registered. ROBO_STEP_COUNT_EN adds step_count.
// Backpressure: none; events are unqueued pulses, same-cycle priority reset > anomaly > mode > step.
module robo_step_ctrl
    import robo_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RUN_DIV    = DEF_RUN_DIV,
    parameter int RST_CYCLES = DEF_RST_CYCLES
`ifdef ROBO_STEP_COUNT_EN
    , parameter int CNT_W    = DEF_CNT_W
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_reset,
    input  logic btn_mode,
    input  logic btn_step,
    input  logic anomaly,
    output logic robo_reset,
    output logic robo_en,
    output logic step_mode,
    output logic halted
`ifdef ROBO_STEP_COUNT_EN
    , output logic [CNT_W-1:0] step_count
`endif
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int PW = $clog2(RUN_DIV + 1);

    logic w_rst_p;
    logic w_mode_p;
    logic w_step_p;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mode;
    logic          w_mode_nxt;
    logic [RW-1:0] r_rst_cnt;
    logic [RW-1:0] w_rst_cnt_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic          w_en_nxt;
    logic          r_robo_reset;
    logic          r_robo_en;
    logic          r_halted;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_reset (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_reset),
        .o_press (w_rst_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_mode),
        .o_press (w_mode_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_step),
        .o_press (w_step_p)
    );

    // Next state, mode, counters and step enable; priority chain drops lower events in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_rst_cnt_nxt = r_rst_cnt;
        w_presc_nxt   = '0;
        w_en_nxt      = 1'b0;
        if (w_rst_p) begin
            w_state_nxt   = RST_HOLD;
            w_rst_cnt_nxt = '0;
        end else begin
            case (r_state)
                RST_HOLD: begin
                    if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
                        w_state_nxt   = (r_mode == MODE_STEP) ? STEP : RUN;
                        w_rst_cnt_nxt = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + RW'(1);
                    end
                end
                RUN: begin
                    if (anomaly) begin
                        w_state_nxt = HALT;
                    end else if (w_mode_p) begin
                        w_mode_nxt  = MODE_STEP;
                        w_state_nxt = STEP;
                    end else if (r_presc == PW'(RUN_DIV - 1)) begin
                        w_en_nxt    = 1'b1;
                        w_presc_nxt = '0;
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                STEP: begin
                    if (anomaly) begin
                        w_state_nxt = HALT;
                    end else if (w_mode_p) begin
                        w_mode_nxt  = MODE_RUN;
                        w_state_nxt = RUN;
                    end else if (w_step_p && !r_robo_en) begin
                        w_en_nxt = 1'b1;
                    end
                end
                HALT: begin
                    if (w_mode_p) begin
                        w_mode_nxt = ~r_mode;
                    end
                end
                default: begin
                    w_state_nxt = RST_HOLD;
                end
            endcase
        end
    end

    // State, mode and counter registers, plus outputs registered from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= RST_HOLD;
            r_mode       <= MODE_RUN;
            r_rst_cnt    <= '0;
            r_presc      <= '0;
            r_robo_reset <= 1'b1;
            r_robo_en    <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_presc      <= w_presc_nxt;
            r_robo_reset <= (w_state_nxt == RST_HOLD);
            r_robo_en    <= w_en_nxt;
            r_halted     <= (w_state_nxt == HALT);
        end
    end

    assign robo_reset = r_robo_reset;
    assign robo_en    = r_robo_en;
    assign step_mode  = r_mode;
    assign halted     = r_halted;

`ifdef ROBO_STEP_COUNT_EN
    logic [CNT_W-1:0] r_step_cnt;

    // Count issued steps, saturating; forced to zero while the robot is held in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_step_cnt <= '0;
        end else if (r_state == RST_HOLD) begin
            r_step_cnt <= '0;
        end else if (r_robo_en && (r_step_cnt != {CNT_W{1'b1}})) begin
            r_step_cnt <= r_step_cnt + CNT_W'(1);
        end
    end

    assign step_count = r_step_cnt;
`endif

endmodule

// File: tb/tb_robo_step_ctrl.sv
// Directed bench for robo_step_ctrl with DEB_CYCLES=4, RUN_DIV=4, RST_CYCLES=2.
// Latency: presses appear 6 clocks after a clean button edge, outputs react one clock later.
// Backpressure: n/a; windows of per-cycle output bits are compared against hand-derived masks.
module tb_robo_step_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_reset = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_step = 1'b0;
    logic anomaly = 1'b0;
    logic robo_reset;
    logic robo_en;
    logic step_mode;
    logic halted;
`ifdef ROBO_STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] v_en;
    logic [31:0] v_rst;
    logic [31:0] v_mode;
    logic [31:0] v_halt;

    always #5 clock = ~clock;

    robo_step_ctrl #(
        .DEB_CYCLES (4),
        .RUN_DIV    (4),
        .RST_CYCLES (2)
`ifdef ROBO_STEP_COUNT_EN
        , .CNT_W    (16)
`endif
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_reset  (btn_reset),
        .btn_mode   (btn_mode),
        .btn_step   (btn_step),
        .anomaly    (anomaly),
        .robo_reset (robo_reset),
        .robo_en    (robo_en),
        .step_mode  (step_mode),
        .halted     (halted)
`ifdef ROBO_STEP_COUNT_EN
        , .step_count (step_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits on a negedge (k=0). btns = {step, mode, reset} are pressed at k=0 and released
    // at k=8; anomaly, if anom_k > 0, is high for exactly the cycle after sample k=anom_k.
    // Bit k-1 of each vector holds the output sampled at negedge k.
    task automatic run_win(input logic [2:0] btns, input int n, input int anom_k,
                           output logic [31:0] o_en, output logic [31:0] o_rst,
                           output logic [31:0] o_mode, output logic [31:0] o_halt);
        logic [31:0] e, r, m, h;
        e = '0; r = '0; m = '0; h = '0;
        {btn_step, btn_mode, btn_reset} = btns;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            e[k-1] = robo_en;
            r[k-1] = robo_reset;
            m[k-1] = step_mode;
            h[k-1] = halted;
            if (k == 8) {btn_step, btn_mode, btn_reset} = 3'b000;
            if (anom_k > 0 && k == anom_k) anomaly = 1'b1;
            if (anom_k > 0 && k == anom_k + 1) anomaly = 1'b0;
        end
        anomaly = 1'b0;
        o_en = e; o_rst = r; o_mode = m; o_halt = h;
    endtask

    initial begin
        logic found;

        // Reset values while reset is held low.
        repeat (2) @(negedge clock);
        check_eq("rst_robo_reset", {31'd0, robo_reset}, 32'd1);
        check_eq("rst_robo_en", {31'd0, robo_en}, 32'd0);
        check_eq("rst_step_mode", {31'd0, step_mode}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);

        // Power-up: robot reset for 2 clocks, then RUN pulses at k=6,10,14.
        reset = 1'b1;
        run_win(3'b000, 16, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("pwr_robo_reset", v_rst, 32'h0001);
        check_eq("pwr_run_en", v_en, 32'h2220);
        check_eq("pwr_step_mode", v_mode, 32'h0);

        // Bouncy mode button: no press while toggling, one press 6 clocks after the stable hold.
        for (int i = 0; i < 10; i++) begin
            btn_mode = (i % 2 == 0);
            @(negedge clock);
        end
        run_win(3'b010, 8, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("bounce_step_mode", v_mode, 32'hC0);
        run_win(3'b000, 20, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("bounce_en_stopped", v_en, 32'h0);
        check_eq("bounce_mode_held", v_mode, 32'hFFFFF);

        // Reset press in STEP: robot reset 2 clocks, mode kept.
        run_win(3'b001, 12, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("step_rst_robo_reset", v_rst, 32'h0C0);
        check_eq("step_rst_mode_kept", v_mode, 32'hFFF);
`ifdef ROBO_STEP_COUNT_EN
        check_eq("cnt_after_reset", {16'd0, step_count}, 32'd0);
`endif

        // Three clean step presses, one enable pulse each at k=7.
        for (int p = 0; p < 3; p++) begin
            run_win(3'b100, 20, 0, v_en, v_rst, v_mode, v_halt);
            check_eq($sformatf("step_press_%0d_en", p), v_en, 32'h40);
        end
`ifdef ROBO_STEP_COUNT_EN
        check_eq("cnt_three_steps", {16'd0, step_count}, 32'd3);
`endif

        // Mode press to RUN (switch at k=7), anomaly in the cycle before the k=11 pulse.
        run_win(3'b010, 14, 10, v_en, v_rst, v_mode, v_halt);
        check_eq("anom_en_suppressed", v_en, 32'h0);
        check_eq("anom_halted", v_halt, 32'h3C00);
        check_eq("anom_step_mode", v_mode, 32'h003F);

        // In HALT: step press ignored, mode press toggles mode only.
        run_win(3'b100, 14, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("halt_step_en", v_en, 32'h0);
        check_eq("halt_step_halted", v_halt, 32'h3FFF);
        run_win(3'b010, 14, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("halt_mode_en", v_en, 32'h0);
        check_eq("halt_mode_halted", v_halt, 32'h3FFF);
        check_eq("halt_mode_toggle", v_mode, 32'h3FC0);

        // Recovery: reset press from HALT with STEP selected.
        run_win(3'b001, 20, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("recov_robo_reset", v_rst, 32'h0C0);
        check_eq("recov_halted", v_halt, 32'h03F);
        check_eq("recov_en_idle", v_en, 32'h0);
        check_eq("recov_step_mode", v_mode, 32'hFFFFF);
        run_win(3'b100, 20, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("recov_step_en", v_en, 32'h40);

        // Reset and mode pressed together: reset wins, mode unchanged.
        run_win(3'b011, 20, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("prio_robo_reset", v_rst, 32'h0C0);
        check_eq("prio_mode_kept", v_mode, 32'hFFFFF);
        check_eq("prio_en", v_en, 32'h0);

        // Back to RUN: switch at k=7, pulses at k=11,15,19.
        run_win(3'b010, 20, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("run_again_mode", v_mode, 32'h3F);
        check_eq("run_again_en", v_en, 32'h44400);

        // Async reset in the middle of a RUN pulse.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clock);
            if (robo_en) found = 1'b1;
        end
        check_eq("run_pulse_found", {31'd0, found}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_robo_reset", {31'd0, robo_reset}, 32'd1);
        check_eq("async_robo_en", {31'd0, robo_en}, 32'd0);
        check_eq("async_halted", {31'd0, halted}, 32'd0);
        check_eq("async_step_mode", {31'd0, step_mode}, 32'd0);
`ifdef ROBO_STEP_COUNT_EN
        check_eq("async_cnt", {16'd0, step_count}, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        run_win(3'b000, 8, 0, v_en, v_rst, v_mode, v_halt);
        check_eq("rerelease_robo_reset", v_rst, 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
